rv_addr_router: RTL

Parametrised data-bus address router between the core's LSU port and N downstream channels (main memory, peripherals, HEX indicator, ...).
- Each region is defined by base, mask and decrement. The router matches the request, translates the address into the channel's MEM_LEN-bit space and forwards it.
- It tracks one outstanding transaction and returns a registered response.
- Unmapped accesses and unresponsive slaves produce an error response instead of a hang.

---
 rtl/rv_addr_router.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/rv_addr_router.sv
// Data-bus address router: decodes LSU requests onto one of N downstream channels,
// tracks one outstanding transaction and returns a registered response or error.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no transaction in flight; decode and forward new requests
// WAIT  | mapped request accepted; waiting on the selected channel
// ERR   | unmapped request accepted; error response on the next edge
module rv_addr_router #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned MEM_LEN   = 20,
    parameter int unsigned N_REGIONS = 3,
    parameter logic [N_REGIONS*XLEN-1:0] REGION_BASE =
        {32'h7FF0_0000, 32'h8000_0000, 32'h0000_0000},
    parameter logic [N_REGIONS*XLEN-1:0] REGION_MASK =
        {32'hFFF0_0000, 32'hFFFF_FFF0, 32'hFFF0_0000},
    parameter logic [N_REGIONS*XLEN-1:0] REGION_DEC =
        {32'h7FEF_FDB0, 32'h8000_0000, 32'h0001_0094},
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      req_i,
    input  logic                      we_i,
    input  logic [XLEN/8-1:0]         be_i,
    input  logic [XLEN-1:0]           addr_i,
    input  logic [XLEN-1:0]           wdata_i,
    output logic                      gnt_o,
    output logic                      rvalid_o,
    output logic [XLEN-1:0]           rdata_o,
    output logic                      err_o,
    output logic [XLEN-1:0]           err_addr_o,
    output logic [N_REGIONS-1:0]      s_req_o,
    output logic                      s_we_o,
    output logic [XLEN/8-1:0]         s_be_o,
    output logic [MEM_LEN-1:0]        s_addr_o,
    output logic [XLEN-1:0]           s_wdata_o,
    input  logic [N_REGIONS-1:0]      s_gnt_i,
    input  logic [N_REGIONS-1:0]      s_rvalid_i,
    input  logic [N_REGIONS*XLEN-1:0] s_rdata_i
);

    localparam int unsigned IDX_W = (N_REGIONS > 1) ? $clog2(N_REGIONS) : 1;
    localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ERR  = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [IDX_W-1:0] sel;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [XLEN-1:0]  req_addr;

    logic             hit;
    logic [IDX_W-1:0] hit_idx;
    logic [XLEN-1:0]  dec_sel;
    logic [XLEN-1:0]  trans;
    logic [XLEN-1:0]  rdata_sel;
    logic             timeout_hit;

    logic             accept;
    logic             resp_set;
    logic             resp_err;
    logic [XLEN-1:0]  resp_data;
    logic             timeout_fire;

    // Walk from the highest index down so the lowest matching region wins.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        dec_sel = '0;
        for (int k = int'(N_REGIONS) - 1; k >= 0; k--) begin
            if ((addr_i & REGION_MASK[k*XLEN +: XLEN]) == REGION_BASE[k*XLEN +: XLEN]) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(k);
                dec_sel = REGION_DEC[k*XLEN +: XLEN];
            end
        end
    end

    assign trans     = addr_i - dec_sel;
    assign s_addr_o  = hit ? trans[MEM_LEN-1:0] : '0;
    assign s_we_o    = we_i;
    assign s_be_o    = be_i;
    assign s_wdata_o = wdata_i;

    assign rdata_sel   = s_rdata_i[sel*XLEN +: XLEN];
    assign cnt_nxt     = cnt + 1'b1;
    assign timeout_hit = (TIMEOUT != 0) && (cnt_nxt == CNT_W'(TIMEOUT));

    always_comb begin
        state_nxt    = state;
        gnt_o        = 1'b0;
        s_req_o      = '0;
        accept       = 1'b0;
        resp_set     = 1'b0;
        resp_err     = 1'b0;
        resp_data    = '0;
        timeout_fire = 1'b0;
        case (state)
            S_IDLE: begin
                if (hit) begin
                    s_req_o[hit_idx] = req_i;
                    gnt_o            = s_gnt_i[hit_idx];
                end else begin
                    gnt_o = req_i;
                end
                accept = req_i && gnt_o;
                if (accept) begin
                    state_nxt = hit ? S_WAIT : S_ERR;
                end
            end
            S_WAIT: begin
                // A response arriving on the last allowed cycle beats the timeout.
                if (s_rvalid_i[sel]) begin
                    resp_set  = 1'b1;
                    resp_data = rdata_sel;
                    state_nxt = S_IDLE;
                end else if (timeout_hit) begin
                    resp_set     = 1'b1;
                    resp_err     = 1'b1;
                    timeout_fire = 1'b1;
                    state_nxt    = S_IDLE;
                end
            end
            S_ERR: begin
                resp_set  = 1'b1;
                resp_err  = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= S_IDLE;
            sel        <= '0;
            cnt        <= '0;
            req_addr   <= '0;
            rvalid_o   <= 1'b0;
            err_o      <= 1'b0;
            rdata_o    <= '0;
            err_addr_o <= '0;
        end else begin
            state    <= state_nxt;
            rvalid_o <= resp_set;
            if (resp_set) begin
                err_o   <= resp_err;
                rdata_o <= resp_data;
            end
            if (accept) begin
                sel      <= hit_idx;
                cnt      <= '0;
                req_addr <= addr_i;
                if (!hit) begin
                    err_addr_o <= addr_i;
                end
            end else if (state == S_WAIT) begin
                cnt <= cnt_nxt;
            end
            if (timeout_fire) begin
                err_addr_o <= req_addr;
            end
        end
    end

endmodule
